if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: RESET_ADDR, 64'h0, first fetch address after reset.
REQ-002 Parameter: DEPTH, 2, capacity of the fetched-instruction buffer; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 jump_flag_i  input  1  redirect request from ctrl.
REQ-006 jump_addr_i  input  64  redirect target.
REQ-007 hold_flag_i  input  2  stall code from ctrl; any nonzero value stalls delivery.
REQ-008 rom_req_o  output  1  fetch request to instruction memory.
REQ-009 rom_addr_o  output  64  fetch address, word aligned.
REQ-010 rom_gnt_i  input  1  request accepted this cycle.
REQ-011 rom_rvalid_i  input  1  read data valid; responses return in request order, latency of 1 or more cycles.
REQ-012 rom_data_i  input  32  returned instruction word.
REQ-013 inst_addr_o  output  64  address of the delivered instruction, to IF_ID.
REQ-014 inst_o  output  32  delivered instruction, to IF_ID.
REQ-015 inst_valid_o  output  1  inst_o/inst_addr_o hold a real fetched instruction.

Function
REQ-016 The block SHALL hold fetch_pc (next request address), resp_pc (address of the next response), an outstanding-request counter, a DEPTH-entry FIFO of {addr,inst}, and state FETCH or FLUSH.
REQ-017 rom_req_o SHALL be 1 only in FETCH, with rst=0, jump_flag_i=0, and outstanding + FIFO count < DEPTH; rom_addr_o = fetch_pc.
REQ-018 On rom_req_o & rom_gnt_i the block SHALL increment outstanding and advance fetch_pc by 4, modulo 2^64 (wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0).
REQ-019 While rom_req_o is 1 and rom_gnt_i is 0, rom_addr_o SHALL stay stable unless a jump arrives, and a jump withdraws the request.
REQ-020 In FETCH, rom_rvalid_i with outstanding > 0 SHALL push {resp_pc, rom_data_i}, decrement outstanding, and advance resp_pc by 4; overflow is impossible by REQ-017.
REQ-021 rom_rvalid_i with outstanding = 0 SHALL be ignored.
REQ-022 Grant and response in the same cycle SHALL leave outstanding unchanged.
REQ-023 FIFO non-empty: inst_valid_o = 1 and inst_o/inst_addr_o = head entry, driven combinationally from the FIFO.
REQ-024 FIFO empty: inst_valid_o = 0, inst_o = 32'h0000_0013 (NOP), inst_addr_o = 0.
REQ-025 The head SHALL pop when inst_valid_o = 1 and hold_flag_i = 2'b00; nonzero hold_flag_i freezes the FIFO contents but not fetching.
REQ-026 Push and pop in the same cycle SHALL keep the count unchanged, with correct ordering.
REQ-027 On jump_flag_i = 1:
- clear the FIFO, with no pop that cycle;
- load fetch_pc and resp_pc with {jump_addr_i[63:2], 2'b00};
- load the discard counter with the outstanding count, minus 1 if rom_rvalid_i is also 1;
- go to FLUSH if that result > 0, else FETCH;
- zero outstanding.
REQ-028 In FLUSH, each rom_rvalid_i SHALL decrement the discard counter and be dropped, with no new requests; reaching 0 returns to FETCH the next cycle.
REQ-029 jump_flag_i SHALL take priority over hold_flag_i, pop, push and grant in the same cycle.
REQ-030 A jump in FLUSH SHALL reload the target and keep the remaining discard count, decremented for a same-cycle rvalid.

Reset
REQ-031 With rst = 1 at a clock edge, the block SHALL set fetch_pc = resp_pc = RESET_ADDR, outstanding = discard = 0, FIFO empty, state FETCH.
REQ-032 During rst = 1, rom_req_o SHALL be 0 and the outputs SHALL be inst_valid_o = 0, inst_o = NOP, inst_addr_o = 0.
REQ-033 Reset mid-operation SHALL abandon in-flight responses without tracking them; the memory model is reset together with the block.

Verification
REQ-034 Reset release, memory always granting with latency 1, hold = 0: requests at 0x0, 0x4, 0x8, ...; inst_addr_o sequence 0x0, 0x4, 0x8 with matching data; no gaps after fill.
REQ-035 hold_flag_i = 2'b01 for 5 cycles with the FIFO full: same head presented each cycle, rom_req_o = 0, no data lost; after release, in-order continuation.
REQ-036 Latency 3 with 2 outstanding, jump to 0x1002 on the same cycle as an rvalid: FIFO empties; 1 response is discarded; next request is 0x1000; first delivered address is 0x1000.
REQ-037 rom_gnt_i held 0 for 4 cycles: rom_addr_o stable at the pending address; a jump on cycle 2 withdraws the request and the next request targets the jump address.
REQ-038 Jump to 0xFFFF_FFFF_FFFF_FFF8: fetched addresses ...FFF8, ...FFFC, 0x0.
REQ-039 Spurious rom_rvalid_i with outstanding = 0: no FIFO change, inst_valid_o stays 0, inst_o = 0x00000013.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage.
// Issues word-aligned fetch requests to instruction memory, collects the
// in-order responses into a small buffer and presents the buffer head to
// IF_ID. A redirect empties the buffer and drops every response still in
// flight from before the redirect; a nonzero hold code freezes delivery
// while fetching continues until the buffer is full.
module if_fetch #(
  parameter logic [63:0] RESET_ADDR = 64'h0,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [63:0] jump_addr_i,
  input  logic [1:0]  hold_flag_i,
  output logic        rom_req_o,
  output logic [63:0] rom_addr_o,
  input  logic        rom_gnt_i,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_data_i,
  output logic [63:0] inst_addr_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  // Pointer width and counter width (counters must be able to hold DEPTH).
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] inst;
  } entry_t;

  state_t          state;
  logic [63:0]     fetch_pc;
  logic [63:0]     resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  entry_t          mem [DEPTH];

  logic            in_fetch;
  logic [CW-1:0]   in_use;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   discard_next;
  logic            grant;
  logic            push;
  logic            pop;
  logic [63:0]     jump_target;
  entry_t          head;

  // Requests granted but not yet answered plus buffered entries never exceed
  // DEPTH, so a returning response always finds a free slot.
  assign in_fetch    = (state == FETCH);
  assign in_use      = outstanding + fifo_count;
  assign rom_req_o   = in_fetch && !rst && !jump_flag_i && (in_use < DEPTH_C);
  assign rom_addr_o  = fetch_pc;
  assign grant       = rom_req_o && rom_gnt_i;

  // A response is accepted only when it belongs to the current stream; a
  // stray rvalid with nothing outstanding is ignored.
  assign push        = in_fetch && rom_rvalid_i && (outstanding != '0)
                       && !jump_flag_i && !rst;

  // Delivery side: the buffer head is shown combinationally.
  assign head         = mem[rd_ptr];
  assign inst_valid_o = !rst && (fifo_count != '0);
  assign inst_o       = inst_valid_o ? head.inst : NOP;
  assign inst_addr_o  = inst_valid_o ? head.addr : 64'h0;
  assign pop          = inst_valid_o && (hold_flag_i == 2'b00) && !jump_flag_i;

  // Clearing the low bits with a mask keeps the whole target word in use.
  assign jump_target = jump_addr_i & ~64'h3;

  // In FETCH the discard counter is zero and in FLUSH nothing is outstanding,
  // so their sum is everything still in flight at the memory.
  assign in_flight = outstanding + discard;

  // Number of stale responses still to drop after a redirect this cycle.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    discard_next = in_flight;
    if (rom_rvalid_i && (in_flight != '0)) begin
      discard_next = in_flight - CW'(1);
    end
  end

  // Control state: PCs, counters, buffer pointers and the FETCH/FLUSH machine.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_ADDR;
      resp_pc     <= RESET_ADDR;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (jump_flag_i) begin
      // Redirect wins over hold, pop, push and grant.
      fetch_pc    <= jump_target;
      resp_pc     <= jump_target;
      outstanding <= '0;
      discard     <= discard_next;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      state       <= (discard_next != '0) ? FLUSH : FETCH;
    end else begin
      // Dropping stale responses; leave FLUSH once the last one is seen.
      if (state == FLUSH && rom_rvalid_i && (discard != '0)) begin
        discard <= discard - CW'(1);
        if (discard == CW'(1)) begin
          state <= FETCH;
        end
      end

      if (grant) begin
        fetch_pc <= fetch_pc + 64'd4;
      end

      if (push) begin
        resp_pc <= resp_pc + 64'd4;
        wr_ptr  <= wr_ptr + PW'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({grant, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Buffer storage: written on every accepted response.
  // NOTE: the storage array has no reset; validity is tracked by fifo_count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: resp_pc, inst: rom_data_i};
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch.
// A behavioural memory keeps the list of in-flight reads (with a stale mark
// after redirects); every granted request pushes its expected delivery into a
// queue, and a separate monitor pops and compares each delivered instruction.
module tb_if_fetch;

  localparam int unsigned DEPTH      = 2;
  localparam logic [63:0] RESET_ADDR = 64'h0;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam int          NCYC       = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [63:0] jump_addr_i;
  logic [1:0]  hold_flag_i;
  logic        rom_req_o;
  logic [63:0] rom_addr_o;
  logic        rom_gnt_i;
  logic        rom_rvalid_i;
  logic [31:0] rom_data_i;
  logic [63:0] inst_addr_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  if_fetch #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_flag_i  (hold_flag_i),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_gnt_i    (rom_gnt_i),
    .rom_rvalid_i (rom_rvalid_i),
    .rom_data_i   (rom_data_i),
    .inst_addr_o  (inst_addr_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] inst;
  } exp_t;

  pend_t       pending[$];   // reads the memory still owes, in order
  exp_t        exp_q[$];     // granted fetches not yet delivered
  logic [63:0] req_pc;       // address the next request must carry
  int          total     = 0;
  int          bad       = 0;
  int          delivered = 0;
  int          cyc       = 0;
  bit          resp_real;

  // Contents of the instruction memory as a function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ a[63:32] ^ 32'h5A3C_96E1;
  endfunction

  function automatic bit any_stale();
    foreach (pending[i]) if (pending[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int live_pending();
    int n = 0;
    foreach (pending[i]) if (!pending[i].stale) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Stimulus and memory model; expectations pushed at grant time.
  initial begin : driver
    int hold_left = 0;
    int gnt_pct = 100, hold_pct = 0, jump_pct = 0, lat_max = 1, spur_pct = 0;
    int lat;
    bit exp_req, exp_valid;

    rst          = 1'b1;
    jump_flag_i  = 1'b0;
    jump_addr_i  = 64'h0;
    hold_flag_i  = 2'b00;
    rom_gnt_i    = 1'b0;
    rom_rvalid_i = 1'b0;
    rom_data_i   = 32'h0;
    req_pc       = RESET_ADDR;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;

      if (c % 500 == 0) begin
        case (c / 500)
          0: begin gnt_pct = 100; hold_pct = 0;  jump_pct = 0; lat_max = 1; spur_pct = 0;  end
          1: begin gnt_pct = 100; hold_pct = 15; jump_pct = 0; lat_max = 1; spur_pct = 0;  end
          2: begin gnt_pct = 70;  hold_pct = 10; jump_pct = 4; lat_max = 3; spur_pct = 10; end
          4: begin gnt_pct = 100; hold_pct = 0;  jump_pct = 0; lat_max = 3; spur_pct = 0;  end
          default: begin
            gnt_pct  = $urandom_range(100, 30);
            hold_pct = $urandom_range(30);
            jump_pct = $urandom_range(10);
            lat_max  = $urandom_range(4, 1);
            spur_pct = $urandom_range(25);
          end
        endcase
      end

      rst = (c < 3) || (c >= 3000 && c < 3002);

      if (hold_left == 0 && $urandom_range(99) < hold_pct) hold_left = $urandom_range(6, 1);
      if (hold_left > 0) begin
        hold_flag_i = 2'($urandom_range(3, 1));
        hold_left--;
      end else begin
        hold_flag_i = 2'b00;
      end

      jump_flag_i = ($urandom_range(99) < jump_pct);
      jump_addr_i = {$urandom, $urandom};
      if ($urandom_range(3) == 0) jump_addr_i[63:8] = '1;
      if (c == 1200) begin jump_flag_i = 1'b1; jump_addr_i = 64'hFFFF_FFFF_FFFF_FFF8; end
      if (c == 2100) begin jump_flag_i = 1'b1; jump_addr_i = 64'h0000_0000_0000_1002; end

      rom_gnt_i = ($urandom_range(99) < gnt_pct);

      resp_real = 1'b0;
      if (pending.size() > 0 && pending[0].due <= c) begin
        rom_rvalid_i = 1'b1;
        rom_data_i   = mem_word(pending[0].addr);
        resp_real    = 1'b1;
      end else if (pending.size() == 0 && $urandom_range(99) < spur_pct) begin
        rom_rvalid_i = 1'b1;
        rom_data_i   = $urandom;
      end else begin
        rom_rvalid_i = 1'b0;
        rom_data_i   = $urandom;
      end

      #1;
      exp_req = !rst && !jump_flag_i && !any_stale() && (exp_q.size() < DEPTH);
      check("rom_req_o", 64'(rom_req_o), 64'(exp_req));
      if (rom_req_o) check("rom_addr_o", rom_addr_o, req_pc);
      exp_valid = !rst && (exp_q.size() > live_pending());
      check("inst_valid_o", 64'(inst_valid_o), 64'(exp_valid));

      #2;
      if (rst) begin
        pending.delete();
        exp_q.delete();
        req_pc = RESET_ADDR;
      end else begin
        if (resp_real) pending.delete(0);
        if (jump_flag_i) begin
          foreach (pending[i]) pending[i].stale = 1'b1;
          exp_q.delete();
          req_pc = jump_addr_i & ~64'h3;
        end else if (rom_req_o && rom_gnt_i) begin
          lat = $urandom_range(lat_max, 1);
          pending.push_back('{addr: req_pc, due: c + lat, stale: 1'b0});
          exp_q.push_back('{addr: req_pc, inst: mem_word(req_pc)});
          req_pc = req_pc + 64'd4;
        end
      end
    end

    @(negedge clk);
    check("delivery_progress", 64'(delivered > 400), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: compares whatever the DUT presents against the queue head.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (inst_valid_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_delivery: got addr %h inst %h want none (cycle %0d)",
                   inst_addr_o, inst_o, cyc);
        end else begin
          check("inst_addr_o", inst_addr_o, exp_q[0].addr);
          check("inst_o", 64'(inst_o), 64'(exp_q[0].inst));
          if (hold_flag_i == 2'b00 && !jump_flag_i && !rst) begin
            exp_q.delete(0);
            delivered++;
          end
        end
      end else begin
        check("inst_o_idle", 64'(inst_o), 64'(NOP));
        check("inst_addr_o_idle", inst_addr_o, 64'h0);
      end
    end
  end

endmodule
